// File: rtl/fifo8x9_ctrl_pkg.sv
// Shared definitions for the 8x9 FIFO controller and its storage block.
package fifo8x9_ctrl_pkg;

    localparam int FIFO_DEPTH = 8;
    localparam int FIFO_AW    = 3;
    localparam int FIFO_DW    = 9;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/fifo_ptr_wrap.sv
// One side (write or read) of the storage pointer: turns an accepted
// access into an increment or, on the last slot, a clear (the wrap).
module fifo_ptr_wrap
    import fifo8x9_ctrl_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = FIFO_AW
) (
    input  logic          ok,
    input  logic [AW-1:0] addr,
    output logic          inc,
    output logic          clr,
    output logic [AW-1:0] next_addr
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    // Last slot clears instead of incrementing; DEPTH is a power of 2 so
    // the local address wraps naturally.
    always_comb begin
        inc       = ok && (addr != LAST);
        clr       = ok && (addr == LAST);
        next_addr = ok ? addr + 1'b1 : addr;
    end

endmodule

// File: rtl/fifo8x9_ctrl.sv
// Pointer/flag controller for the 8-deep x 9-bit FIFO storage block.
// Storage strobes are combinational so the storage acts on the same edge
// that updates the controller's own copy of the pointers.
module fifo8x9_ctrl
    import fifo8x9_ctrl_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = FIFO_AW
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_req,
    input  logic        rd_req,
    input  logic        flush,
    output logic        wren,
    output logic        WrInc,
    output logic        WrPtrClr,
    output logic        rden,
    output logic        RdInc,
    output logic        RdPtrClr,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count,
    output logic        rd_valid,
    output logic        overflow,
    output logic        underflow
);

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    state_e        state_q, state_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [AW:0]   count_q, count_d;
    logic          rd_valid_q, rd_valid_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic          run, clr_all, wr_ok, rd_ok;
    logic          wr_inc, wr_clr, rd_inc, rd_clr;
    logic [AW-1:0] wr_nxt, rd_nxt;

    // Flags and request acceptance; a write when full only goes in if a
    // read frees a slot on the same edge.
    always_comb begin
        full    = (count_q == CNT_FULL);
        empty   = (count_q == '0);
        run     = rst && (state_q == RUN);
        clr_all = rst && (state_q != RUN);
        rd_ok   = run && rd_req && !empty;
        wr_ok   = run && wr_req && (!full || rd_ok);
    end

    fifo_ptr_wrap #(.DEPTH(DEPTH), .AW(AW)) u_wr_ptr (
        .ok        (wr_ok),
        .addr      (wr_addr_q),
        .inc       (wr_inc),
        .clr       (wr_clr),
        .next_addr (wr_nxt)
    );

    fifo_ptr_wrap #(.DEPTH(DEPTH), .AW(AW)) u_rd_ptr (
        .ok        (rd_ok),
        .addr      (rd_addr_q),
        .inc       (rd_inc),
        .clr       (rd_clr),
        .next_addr (rd_nxt)
    );

    // Storage strobes: INIT and FLUSH clear both storage pointers.
    always_comb begin
        wren     = wr_ok;
        WrInc    = wr_inc;
        WrPtrClr = wr_clr || clr_all;
        rden     = rd_ok;
        RdInc    = rd_inc;
        RdPtrClr = rd_clr || clr_all;
        count    = count_q;
        rd_valid = rd_valid_q;
        overflow = overflow_q;
        underflow = underflow_q;
    end

    // Next-state logic: requests only matter in RUN; FLUSH wipes the
    // occupancy and errors in its single cycle.
    always_comb begin
        state_d     = state_q;
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        count_d     = count_q;
        rd_valid_d  = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        case (state_q)
            INIT: begin
                state_d = RUN;
            end
            RUN: begin
                wr_addr_d   = wr_nxt;
                rd_addr_d   = rd_nxt;
                rd_valid_d  = rd_ok;
                overflow_d  = overflow_q || (wr_req && !wr_ok);
                underflow_d = underflow_q || (rd_req && empty);
                if (wr_ok && !rd_ok)
                    count_d = count_q + 1'b1;
                else if (rd_ok && !wr_ok)
                    count_d = count_q - 1'b1;
                if (flush)
                    state_d = FLUSH;
            end
            FLUSH: begin
                state_d     = RUN;
                wr_addr_d   = '0;
                rd_addr_d   = '0;
                count_d     = '0;
                overflow_d  = 1'b0;
                underflow_d = 1'b0;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= INIT;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            count_q     <= count_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: tb/tb_fifo8x9_ctrl.sv
// Self-checking bench for fifo8x9_ctrl: a hand-computed vector table for
// bring-up, fill and full-with-simultaneous-access, hand sequences for
// flush/underflow/reset, then random traffic against a queue model.
module tb_fifo8x9_ctrl;

    logic       clk = 1'b0;
    logic       rst, wr_req, rd_req, flush;
    logic       wren, WrInc, WrPtrClr, rden, RdInc, RdPtrClr;
    logic       full, empty, rd_valid, overflow, underflow;
    logic [3:0] count;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of occupied slots plus slot counters.
    int  mode;          // 0 = init pending, 1 = running, 2 = flush pending
    int  q[$];
    int  wslot, rslot;
    bit  m_rv, m_ov, m_un;

    // Output vector: {wren,WrInc,WrPtrClr,rden,RdInc,RdPtrClr,full,empty,count,rd_valid,overflow,underflow}
    typedef struct {
        bit          r, w, rd, f;
        logic [14:0] exp;
    } vec_t;

    vec_t tab[17];

    fifo8x9_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .wr_req    (wr_req),
        .rd_req    (rd_req),
        .flush     (flush),
        .wren      (wren),
        .WrInc     (WrInc),
        .WrPtrClr  (WrPtrClr),
        .rden      (rden),
        .RdInc     (RdInc),
        .RdPtrClr  (RdPtrClr),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .rd_valid  (rd_valid),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    function automatic vec_t row(bit r, bit w, bit rd, bit f, logic [5:0] s,
                                 bit fu, bit em, logic [3:0] c, bit rv, bit ov, bit un);
        vec_t v;
        v.r = r; v.w = w; v.rd = rd; v.f = f;
        v.exp = {s, fu, em, c, rv, ov, un};
        return v;
    endfunction

    task automatic check(input string nm, input logic [14:0] act, input logic [14:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b required %b (strobes|full|empty|count|rv|ov|un)", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        wslot = 0; rslot = 0;
        m_rv = 0; m_ov = 0; m_un = 0;
    endtask

    // Drive one cycle, compare mid-cycle against the model (and the table
    // value when given), then advance the model across the edge.
    task automatic step(input bit r, input bit w, input bit rd, input bit f,
                        input string nm, input bit use_tab, input logic [14:0] texp);
        bit rdok, wrok;
        int n;
        logic [14:0] exp, act;
        rst = r; wr_req = w; rd_req = rd; flush = f;
        @(negedge clk);
        n    = q.size();
        rdok = r && mode == 1 && rd && n > 0;
        wrok = r && mode == 1 && w && (n < 8 || rdok);
        if (!r)
            exp[14:9] = 6'b000000;
        else if (mode != 1)
            exp[14:9] = 6'b001001;
        else
            exp[14:9] = {wrok, wrok && wslot != 7, wrok && wslot == 7,
                         rdok, rdok && rslot != 7, rdok && rslot == 7};
        exp[8]   = (n == 8);
        exp[7]   = (n == 0);
        exp[6:3] = 4'(n);
        exp[2]   = m_rv;
        exp[1]   = m_ov;
        exp[0]   = m_un;
        act = {wren, WrInc, WrPtrClr, rden, RdInc, RdPtrClr,
               full, empty, count, rd_valid, overflow, underflow};
        check({nm, " model"}, act, exp);
        if (use_tab)
            check({nm, " table"}, act, texp);
        @(posedge clk);
        if (!r) begin
            mode = 0;
            model_clear();
        end else if (mode == 0) begin
            mode = 1;
            m_rv = 0;
        end else if (mode == 2) begin
            mode = 1;
            model_clear();
        end else begin
            m_ov = m_ov || (w && !wrok);
            m_un = m_un || (rd && n == 0);
            m_rv = rdok;
            if (rdok) begin
                void'(q.pop_front());
                rslot = (rslot + 1) % 8;
            end
            if (wrok) begin
                q.push_back(wslot);
                wslot = (wslot + 1) % 8;
            end
            if (f) mode = 2;
        end
        #1;
    endtask

    initial begin
        // Bring-up, fill to full, overflow, then full with simultaneous r/w.
        tab[0]  = row(0,0,0,0, 6'b000000, 0,1,4'd0, 0,0,0);
        tab[1]  = row(1,0,0,0, 6'b001001, 0,1,4'd0, 0,0,0);
        tab[2]  = row(1,0,0,0, 6'b000000, 0,1,4'd0, 0,0,0);
        tab[3]  = row(1,1,0,0, 6'b110000, 0,1,4'd0, 0,0,0);
        for (int i = 4; i <= 9; i++)
            tab[i] = row(1,1,0,0, 6'b110000, 0,0,4'(i-3), 0,0,0);
        tab[10] = row(1,1,0,0, 6'b101000, 0,0,4'd7, 0,0,0);
        tab[11] = row(1,1,0,0, 6'b000000, 1,0,4'd8, 0,0,0);
        tab[12] = row(1,0,0,0, 6'b000000, 1,0,4'd8, 0,1,0);
        tab[13] = row(1,1,1,0, 6'b110110, 1,0,4'd8, 0,1,0);
        tab[14] = row(1,1,1,0, 6'b110110, 1,0,4'd8, 1,1,0);
        tab[15] = row(1,1,1,0, 6'b110110, 1,0,4'd8, 1,1,0);
        tab[16] = row(1,0,0,0, 6'b000000, 1,0,4'd8, 1,1,0);

        rst = 0; wr_req = 0; rd_req = 0; flush = 0;
        repeat (2) @(posedge clk);
        #1;
        mode = 0;
        model_clear();

        for (int i = 0; i < 17; i++)
            step(tab[i].r, tab[i].w, tab[i].rd, tab[i].f, $sformatf("tab%0d", i), 1, tab[i].exp);

        // Flush from full, then 5 writes, 5 reads, and a read while empty.
        step(1,0,0,1, "flush_cmd", 0, '0);
        step(1,0,0,0, "flush_cyc", 0, '0);
        for (int i = 0; i < 5; i++) step(1,1,0,0, "wr5", 0, '0);
        for (int i = 0; i < 5; i++) step(1,0,1,0, "rd5", 0, '0);
        step(1,0,0,0, "rd5_last_valid", 0, '0);
        step(1,0,1,0, "rd_empty", 0, '0);
        step(1,0,0,0, "underflow_sticky", 0, '0);

        // Count 5 then flush; next write must land in slot 0.
        for (int i = 0; i < 5; i++) step(1,1,0,0, "wr_to5", 0, '0);
        step(1,0,0,1, "flush5_cmd", 0, '0);
        step(1,1,1,0, "flush5_cyc", 0, '0);
        step(1,1,0,0, "wr_slot0", 0, '0);
        step(1,1,0,0, "wr_slot1", 0, '0);
        step(1,1,0,0, "wr_slot2", 0, '0);

        // Reset mid-stream with a write pending.
        step(0,1,0,0, "rst_mid", 0, '0);
        step(1,1,1,0, "rst_init", 0, '0);
        step(1,0,0,0, "rst_run", 0, '0);

        // Random traffic with phase-biased write density and rare flush/reset.
        for (int i = 0; i < 600; i++) begin
            bit r, w, rd, f;
            int wp;
            wp = ((i / 40) % 2 == 0) ? 75 : 25;
            r  = ($urandom_range(0, 149) != 0);
            w  = ($urandom_range(0, 99) < wp);
            rd = ($urandom_range(0, 99) < (100 - wp));
            f  = ($urandom_range(0, 49) == 0);
            step(r, w, rd, f, $sformatf("rnd%0d", i), 0, '0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
